// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, with sign fix-up applied on the final iteration.
module riscv_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [2:0]        funct3_reg;
  logic              a_neg_reg, b_neg_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg, b_mag_reg, result_reg;

  logic              accept, a_neg, b_neg, div_zero, div_ovf, special, last_iter;
  logic [DATA_W-1:0] a_mag, b_mag, special_result;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] hi_step, lo_step, quotient, remainder, calc_result;
  logic [2*DATA_W-1:0] product, product_fixed;

  assign accept    = (state_reg == IDLE) && start && !flush;
  assign last_iter = (count_reg == CNT_W'(DATA_W - 1));

  // Operand decode at accept: MULH/DIV/REM sign both operands, MULHSU only op_a.
  always_comb begin
    a_neg    = ((funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6))
               && op_a[DATA_W-1];
    b_neg    = ((funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6)) && op_b[DATA_W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_result = funct3[1] ? op_a : '1;
    else          special_result = funct3[1] ? '0 : op_a;
  end

  // One iteration. Multiply: lo holds the multiplier, hi accumulates and both shift right.
  // Divide: lo holds the dividend and collects quotient bits, hi is the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_mag_reg} : '0);
    div_shift = {hi_reg, lo_reg[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_reg});
    div_diff  = div_shift - {1'b0, b_mag_reg};
    if (!funct3_reg[2]) begin
      hi_step = mul_sum[DATA_W:1];
      lo_step = {mul_sum[0], lo_reg[DATA_W-1:1]};
    end else begin
      hi_step = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      lo_step = {lo_reg[DATA_W-2:0], div_ge};
    end
    product       = {hi_step, lo_step};
    product_fixed = (a_neg_reg ^ b_neg_reg) ? -product : product;
    quotient      = (a_neg_reg ^ b_neg_reg) ? -lo_step : lo_step;
    remainder     = a_neg_reg ? -hi_step : hi_step;
    case (funct3_reg)
      3'd0:                calc_result = product_fixed[DATA_W-1:0];
      3'd1, 3'd2, 3'd3:    calc_result = product_fixed[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:          calc_result = quotient;
      default:             calc_result = remainder;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      funct3_reg <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_mag_reg  <= '0;
      result_reg <= '0;
    end else if (accept) begin
      count_reg  <= '0;
      funct3_reg <= funct3;
      a_neg_reg  <= a_neg;
      b_neg_reg  <= b_neg;
      hi_reg     <= '0;
      lo_reg     <= a_mag;
      b_mag_reg  <= b_mag;
      if (special) result_reg <= special_result;
    end else if ((state_reg == CALC) && !flush) begin
      count_reg <= count_reg + 1'b1;
      hi_reg    <= hi_step;
      lo_reg    <= lo_step;
      if (last_iter) result_reg <= calc_result;
    end
  end

  assign ready  = (state_reg == IDLE);
  assign busy   = (state_reg == CALC) || (state_reg == DONE);
  assign done   = (state_reg == DONE) && !flush;
  assign result = result_reg;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit (DATA_W=32): expected results are queued at
// issue and compared whenever done pulses; latency, flush, reset and ignored starts are checked.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  riscv_muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, su;
    logic [63:0] p;
    logic signed [31:0] x, y;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    su = {32'b0, b};
    x = a;
    y = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * su; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return x / y;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return x % y;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
    end
  end

  // mode 0: normal, 1: extra start while busy, 2: flush at T+10, 3: reset at T+5.
  // Called right after a falling edge with the unit idle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input logic [31:0] exp);
    int lat, k, dc0;
    logic [31:0] prev;
    lat  = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    prev = result;
    dc0  = done_cnt;
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    if (mode < 2) exp_q.push_back(exp);
    $display("op funct3=%0d a=0x%08h b=0x%08h mode=%0d expect=0x%08h", f3, a, b, mode, exp);
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (done) break;
      if (mode == 1) begin start = (k == 5); op_a = ~a; funct3 = 3'd3; end
      if (mode == 2 && k == 10) flush = 1'b1;
      if (mode == 3 && k == 5) reset = 1'b1;
      if (mode >= 2 && k == ((mode == 2) ? 11 : 6)) begin
        flush = 1'b0; reset = 1'b0;
        break;
      end
    end
    if (mode < 2) begin
      check("latency", k, lat);
      @(negedge clk);
      check("ready_after", ready, 1'b1);
      if (mode == 1) begin
        repeat (40) @(negedge clk);
        check("busy_start_ignored", done_cnt, dc0 + 1);
      end
    end else begin
      check("abort_ready", ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, (mode == 2) ? prev : 32'h0);
      repeat (40) @(negedge clk);
      check("abort_no_done", done_cnt, dc0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    logic [2:0] f3;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'h0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 0, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 0, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 0, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0);

    run_op(3'd4, 32'd1000, 32'd3, 2, 32'd333);
    run_op(3'd0, 32'd9, 32'd11, 1, 32'd99);

    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; start = 1'b1; flush = 1'b1;
    dc0 = done_cnt;
    $display("op start+flush in idle");
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush_ready", ready, 1'b1);
    check("startflush_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("startflush_no_done", done_cnt, dc0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 3, 32'hFFFF_FFEB);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 6 == 0) b = 32'd0;
      if (i % 6 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 6 == 5) b = b >> 20;
      run_op(f3, a, b, 0, ref_model(f3, a, b));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
